// File: rtl/dualmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dualmem_pkg
// Description : Shared constants and request bundle for the dual-port RAM
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dualmem_pkg;

    localparam int DUALMEM_AW = 11;
    localparam int DUALMEM_DW = 64;
    localparam int DUALMEM_BW = DUALMEM_DW / 8;

    typedef struct packed {
        logic                  we;
        logic [DUALMEM_AW-1:0] addr;
        logic [DUALMEM_DW-1:0] wdata;
        logic [DUALMEM_BW-1:0] be;
    } dualmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dualmem_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : dualmem_port_arb
// Description : Two-requester round-robin arbiter for one port of a
//               byte-writable synchronous block RAM. Optional grant locking
//               enabled with macro DUALMEM_PORT_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dualmem_port_arb
    import dualmem_pkg::*;
#(
    parameter int AW = DUALMEM_AW,
    parameter int DW = DUALMEM_DW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [DW/8-1:0] r0_be,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    input  logic [DW/8-1:0] r1_be,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,

`ifdef DUALMEM_PORT_ARB_LOCK_EN
    input  logic          r0_lock,
    input  logic          r1_lock,
`endif

    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic [DW/8-1:0] mem_we,
    input  logic [DW-1:0] mem_dout
);

    localparam int BW = DW / 8;

    logic r_rst_q;
    logic r_last_gnt;
    logic r_rvalid0;
    logic r_rvalid1;

    logic w_en;
    logic w_hold0;
    logic w_hold1;
    logic w_gnt0;
    logic w_gnt1;

`ifdef DUALMEM_PORT_ARB_LOCK_EN
    logic r_locked;
    logic r_owner;

    // A lock only binds while its owner keeps requesting; dropping req frees the port at once.
    assign w_hold0 = r_locked && !r_owner && r0_req;
    assign w_hold1 = r_locked &&  r_owner && r1_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked <= 1'b0;
            r_owner  <= 1'b0;
        end else if (w_gnt0) begin
            r_locked <= r0_lock;
            r_owner  <= 1'b0;
        end else if (w_gnt1) begin
            r_locked <= r1_lock;
            r_owner  <= 1'b1;
        end else if (r_locked && !(r_owner ? r1_req : r0_req)) begin
            r_locked <= 1'b0;
        end
    end
`else
    assign w_hold0 = 1'b0;
    assign w_hold1 = 1'b0;
`endif

    // Grants are blanked during reset and for the cycle after it.
    assign w_en = !rst && !r_rst_q;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_en) begin
            if (w_hold0) begin
                w_gnt0 = 1'b1;
            end else if (w_hold1) begin
                w_gnt1 = 1'b1;
            end else if (r0_req && r1_req) begin
                w_gnt0 = r_last_gnt;
                w_gnt1 = !r_last_gnt;
            end else begin
                w_gnt0 = r0_req;
                w_gnt1 = r1_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_q    <= 1'b1;
            r_last_gnt <= 1'b1;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_rst_q   <= 1'b0;
            r_rvalid0 <= w_gnt0 && !r0_we;
            r_rvalid1 <= w_gnt1 && !r1_we;
            if (w_gnt0) begin
                r_last_gnt <= 1'b0;
            end else if (w_gnt1) begin
                r_last_gnt <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_en   = w_gnt0 || w_gnt1;
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = '0;
        if (w_gnt0) begin
            mem_addr = r0_addr;
            mem_din  = r0_wdata;
            mem_we   = r0_we ? r0_be : {BW{1'b0}};
        end else if (w_gnt1) begin
            mem_addr = r1_addr;
            mem_din  = r1_wdata;
            mem_we   = r1_we ? r1_be : {BW{1'b0}};
        end
    end

    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;
    assign r0_rvalid = r_rvalid0 && !rst;
    assign r1_rvalid = r_rvalid1 && !rst;
    assign r0_rdata  = r0_rvalid ? mem_dout : '0;
    assign r1_rdata  = r1_rvalid ? mem_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_dualmem_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_dualmem_port_arb
// Description : Scoreboard bench for dualmem_port_arb with a RAM model and a
//               rule-level arbitration/memory reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dualmem_port_arb;
    import dualmem_pkg::*;

    localparam int AW = DUALMEM_AW;
    localparam int DW = DUALMEM_DW;
    localparam int BW = DUALMEM_BW;
`ifdef DUALMEM_PORT_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_req = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic [BW-1:0] r0_be = '0;
    logic          r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic [BW-1:0] r1_be = '0;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [BW-1:0] mem_we;
    logic [DW-1:0] mem_dout = '0;

    dualmem_port_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_be(r0_be), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_be(r1_be), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
`ifdef DUALMEM_PORT_ARB_LOCK_EN
        .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical RAM stand-in: synchronous read, per-byte write.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < BW; b++)
                if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
            mem_dout <= ram[mem_addr];
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: shadow memory, round-robin pointer, lock ownership.
    typedef struct { int cyc; logic [63:0] data; } exp_t;
    exp_t          q0[$], q1[$];
    logic [DW-1:0] sh [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) sh[i] = '0;
    bit m_last = 1'b1, m_locked = 1'b0, m_owner = 1'b0, m_prev_rst = 1'b1;

    always @(negedge clk) begin : mon
        bit e0, e1, own_req, x0, x1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (rst) begin
            q0.delete(); q1.delete();
            m_last = 1'b1; m_locked = 1'b0; m_owner = 1'b0;
        end
        own_req = m_owner ? r1_req : r0_req;
        if (!rst && !m_prev_rst) begin
            if (m_locked && own_req) begin
                if (m_owner) e1 = 1'b1; else e0 = 1'b1;
            end else if (r0_req && r1_req) begin
                if (m_last) e0 = 1'b1; else e1 = 1'b1;
            end else begin
                e0 = r0_req;
                e1 = r1_req;
            end
        end
        chk("r0_gnt", r0_gnt, e0);
        chk("r1_gnt", r1_gnt, e1);
        chk("mem_en", mem_en, e0 | e1);
        chk("mem_addr", mem_addr, e0 ? r0_addr : e1 ? r1_addr : '0);
        chk("mem_din", mem_din, e0 ? r0_wdata : e1 ? r1_wdata : '0);
        chk("mem_we", mem_we, (e0 && r0_we) ? r0_be : (e1 && r1_we) ? r1_be : '0);

        x0 = (q0.size() > 0) && (q0[0].cyc == cyc);
        x1 = (q1.size() > 0) && (q1[0].cyc == cyc);
        chk("r0_rvalid", r0_rvalid, x0);
        chk("r0_rdata", r0_rdata, x0 ? q0[0].data : 64'h0);
        chk("r1_rvalid", r1_rvalid, x1);
        chk("r1_rdata", r1_rdata, x1 ? q1[0].data : 64'h0);
        if (q0.size() > 0 && q0[0].cyc <= cyc) void'(q0.pop_front());
        if (q1.size() > 0 && q1[0].cyc <= cyc) void'(q1.pop_front());

        if (e0) begin
            if (r0_we) begin
                for (int b = 0; b < BW; b++)
                    if (r0_be[b]) sh[r0_addr][b*8 +: 8] = r0_wdata[b*8 +: 8];
            end else begin
                q0.push_back('{cyc + 1, sh[r0_addr]});
            end
            m_last = 1'b0; m_owner = 1'b0; m_locked = LOCK_EN && r0_lock;
        end else if (e1) begin
            if (r1_we) begin
                for (int b = 0; b < BW; b++)
                    if (r1_be[b]) sh[r1_addr][b*8 +: 8] = r1_wdata[b*8 +: 8];
            end else begin
                q1.push_back('{cyc + 1, sh[r1_addr]});
            end
            m_last = 1'b1; m_owner = 1'b1; m_locked = LOCK_EN && r1_lock;
        end else if (m_locked && !own_req) begin
            m_locked = 1'b0;
        end
        m_prev_rst = rst;
    end

    function automatic dualmem_req_t mk(input logic we, input logic [AW-1:0] a,
                                        input logic [DW-1:0] d, input logic [BW-1:0] be);
        mk.we = we; mk.addr = a; mk.wdata = d; mk.be = be;
    endfunction

    // Present up to one request per requester and hold each until granted.
    task automatic xfer(input bit v0, input dualmem_req_t a, input bit l0,
                        input bit v1, input dualmem_req_t b, input bit l1);
        bit p0, p1;
        int t;
        p0 = v0; p1 = v1; t = 0;
        @(posedge clk); #1;
        r0_req = p0; r0_we = a.we; r0_addr = a.addr; r0_wdata = a.wdata; r0_be = a.be; r0_lock = l0;
        r1_req = p1; r1_we = b.we; r1_addr = b.addr; r1_wdata = b.wdata; r1_be = b.be; r1_lock = l1;
        while (p0 || p1) begin
            @(negedge clk);
            if (r0_gnt) p0 = 1'b0;
            if (r1_gnt) p1 = 1'b0;
            if (p0 || p1) begin
                t++;
                if (t >= 40) begin
                    n_cmp++; n_fail++;
                    $display("FAIL xfer_timeout: waited %0d cycles, required grant within 40", t);
                    p0 = 1'b0; p1 = 1'b0;
                end
                @(posedge clk); #1;
                r0_req = p0; r1_req = p1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            r0_req = 1'b0; r1_req = 1'b0; r0_lock = 1'b0; r1_lock = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    dualmem_req_t NONE;
    assign NONE = '0;

    initial begin
        bit v0, v1, l0, l1;
        dualmem_req_t ra, rb;
        int c0, c1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full write then read-back.
        xfer(1, mk(1, 11'h005, 64'h1122334455667788, 8'hFF), 0, 0, NONE, 0);
        xfer(1, mk(0, 11'h005, '0, '0), 0, 0, NONE, 0);
        @(negedge clk);
        chk("t1_rdata", r0_rdata, 64'h1122334455667788);

        // Both requesters held high for six contended cycles.
        c0 = 0; c1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            r0_req = 1'b1; r0_we = 1'b0; r0_addr = 11'(11'h100 + c0);
            r1_req = 1'b1; r1_we = 1'b0; r1_addr = 11'(11'h200 + c1);
            @(negedge clk);
            if (r0_gnt) c0++;
            if (r1_gnt) c1++;
        end
        idle(1);
        chk("contend_r0_grants", c0, 3);
        chk("contend_r1_grants", c1, 3);

        // Partial and empty byte-enable writes.
        xfer(1, mk(1, 11'h000, 64'hFFFFFFFFFFFFFFFF, 8'h0F), 0, 0, NONE, 0);
        xfer(1, mk(0, 11'h000, '0, '0), 0, 0, NONE, 0);
        @(negedge clk);
        chk("partial_rdata", r0_rdata, 64'h00000000FFFFFFFF);
        xfer(0, NONE, 0, 1, mk(1, 11'h000, 64'hA5A5A5A5A5A5A5A5, 8'h00), 0);
        xfer(0, NONE, 0, 1, mk(0, 11'h000, '0, '0), 0);
        @(negedge clk);
        chk("be0_rdata", r1_rdata, 64'h00000000FFFFFFFF);

        // r1 back-to-back reads across the address wrap.
        xfer(0, NONE, 0, 1, mk(0, 11'h7FF, '0, '0), 0);
        xfer(0, NONE, 0, 1, mk(0, 11'(11'h7FF + 11'h001), '0, '0), 0);
        xfer(0, NONE, 0, 1, mk(0, 11'h001, '0, '0), 0);
        idle(2);

        // Reset right after a granted read, then contend.
        xfer(0, NONE, 0, 1, mk(0, 11'h005, '0, '0), 0);
        do_reset();
        xfer(1, mk(0, 11'h005, '0, '0), 0, 1, mk(0, 11'h000, '0, '0), 0);
        idle(2);

`ifdef DUALMEM_PORT_ARB_LOCK_EN
        do_reset();
        idle(2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            r0_req = 1'b1; r0_we = 1'b0; r0_addr = 11'(11'h010 + i); r0_lock = (i < 3);
            r1_req = 1'b1; r1_we = 1'b0; r1_addr = 11'h020; r1_lock = 1'b0;
            @(negedge clk);
            chk("lock_r1_blocked", r1_gnt, 1'b0);
        end
        @(posedge clk); #1;
        r0_addr = 11'h014; r0_lock = 1'b0;
        @(negedge clk);
        chk("lock_release_r1", r1_gnt, 1'b1);
        idle(2);
`endif

        // Randomized traffic.
        repeat (300) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            ra = mk(1'($urandom_range(0, 1)), 11'($urandom_range(0, 31)),
                    {$urandom, $urandom}, 8'($urandom));
            rb = mk(1'($urandom_range(0, 1)), 11'($urandom_range(0, 31)),
                    {$urandom, $urandom}, 8'($urandom));
            l0 = LOCK_EN && ($urandom_range(0, 3) == 0);
            l1 = LOCK_EN && ($urandom_range(0, 3) == 0);
            xfer(v0, ra, l0, v1, rb, l1);
        end
        idle(3);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
